group_mem_writer: RTL and testbench
===================================

Name: group_mem_writer

Overview:
- Fills the ping-pong group memory that the frame generator reads.
- Accepts 12-bit words from the LCB/MCM collection path over a valid/ready handshake.
- Writes the words sequentially into the memory half that the frame generator is not currently reading.
- Tracks the generator's bank-switch signal, pads short groups on request, and flags overflow and underrun.

Parameters:
- ADDR_W, 10, word address width per bank (bank depth 2^ADDR_W = 1024).
- DATA_W, 12, word width.
- FILL_WORD, 12'h000, value written during padding.

Ports:
- clk  in  1  system clock (12.582912 MHz).
- reset  in  1  asynchronous, active-low.
- iSwitch  in  1  bank select from frame generator; the generator reads bank iSwitch. Same clock domain.
- iData  in  DATA_W  input word.
- iValid  in  1  iData valid.
- oReady  out  1  word accepted when iValid && oReady.
- iFlush  in  1  1-cycle pulse: pad the rest of the current bank with FILL_WORD.
- oWrEn  out  1  memory write enable.
- oWrAddr  out  ADDR_W+1  {bank, word address}.
- oWrData  out  DATA_W  memory write data.
- oBankFull  out  1  level; current bank completely written.
- oOverflow  out  1  1-cycle pulse; a word was dropped.
- oUnderrun  out  1  1-cycle pulse; switch arrived before the bank was full.

Behaviour:
- Reset values:
  - State FILL; cntAddr=0; swPrev=0; wrBank=1.
  - oReady=1; oWrEn=0; oWrAddr=0; oWrData=0.
  - oBankFull=0; oOverflow=0; oUnderrun=0.
- Edge detection: edge = (iSwitch != swPrev). swPrev <= iSwitch every cycle.
- States:
  - FILL: oReady=1. On accept, write iData at {wrBank,cntAddr} and increment cntAddr. If the accepted word is at address 2^ADDR_W-1, go to FULL.
  - PAD: oReady=0. Write FILL_WORD at {wrBank,cntAddr} each cycle. On address 2^ADDR_W-1, go to FULL.
  - FULL: oReady=0, oBankFull=1. No writes.
- iFlush:
  - In FILL with cntAddr != 0: go to PAD. A word accepted in the same cycle is written first; padding starts at the next address.
  - In FILL with cntAddr == 0: ignored.
  - In PAD or FULL: ignored.
- Switch edge (highest priority, any state):
  - wrBank <= ~iSwitch; cntAddr <= 0; state <= FILL; oBankFull <= 0.
  - If the state was not FULL, pulse oUnderrun. The unwritten words of the old bank keep stale contents, as decided.
  - If iValid && oReady in the edge cycle, the word goes to {~iSwitch, 0} and cntAddr <= 1.
- Overflow: iValid && !oReady, with no edge in that cycle, pulses oOverflow; the word is dropped.
- Write port: registered, 1 clk latency from accept to oWrEn/oWrAddr/oWrData. oWrEn is high for exactly one cycle per write.
- Arithmetic: cntAddr is ADDR_W bits, unsigned, and wraps to 0 only via the FULL→edge path. No increment past 2^ADDR_W-1.
- Reset mid-operation: all state is discarded, with no partial write. The first post-reset bank is bank 1.

Optional Feature:
- GMW_STATS_EN defined:
  - Adds outputs oOvfCnt[7:0] and oUndCnt[7:0].
  - Saturating counts of oOverflow and oUnderrun pulses; reset to 0; saturate at 255.
  - Input iStatClr (1-cycle) clears both; a simultaneous event counts as 1 after the clear.
- GMW_STATS_EN undefined: no such ports, logic or inputs.

Decomposition:
- Shared package gmw_pkg:
  - State enum FILL/PAD/FULL.
  - Constants BANK_DEPTH=1024 and FILL_WORD default.
  - The 12-bit word type shared with the frame generator.
- One sub-module, gmw_sat_cnt: 8-bit saturating counter with clear. Instantiated twice, only under GMW_STATS_EN.

Test Plan:
- Reset release, iSwitch=0, stream 1024 words 0x000..0x3FF:
  - oWrAddr runs 0x400..0x7FF with data equal to address LSBs.
  - oBankFull rises after the last write; oReady=0.
- Bank full, iValid held 3 cycles:
  - 3 oOverflow pulses, no oWrEn.
  - Then toggle iSwitch→1: writes resume at 0x000, oBankFull=0, no oUnderrun.
- Write 100 words, then iFlush:
  - 924 FILL_WORD writes at addresses 100..1023 on consecutive cycles.
  - oBankFull; no underrun on the next switch.
- Write 500 words, then toggle iSwitch:
  - oUnderrun pulse.
  - A word presented in the edge cycle is written at {~iSwitch,0}; the next word at address 1.
- Assert reset mid-PAD at address 600:
  - Outputs return to reset values.
  - The next accepted word is written at 0x400.
- With GMW_STATS_EN, force 300 overflows:
  - oOvfCnt=255.
  - iStatClr coincident with an overflow gives oOvfCnt=1.

Source files
------------

// File: rtl/gmw_pkg.sv
// Shared types and constants for the group memory writer and the frame generator.
// Consumers: group_mem_writer and gmw_sat_cnt (the latter only when GMW_STATS_EN is defined).
package gmw_pkg;

  localparam int BANK_DEPTH = 1024;
  localparam int WORD_W     = 12;

  typedef logic [WORD_W-1:0] gmw_word_t;

  localparam gmw_word_t FILL_WORD_DEF = 12'h000;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    FULL = 2'd2
  } gmw_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/gmw_sat_cnt.sv
// 8-bit saturating event counter with synchronous clear.
// A clear and an event in the same cycle leave the count at 1.
module gmw_sat_cnt
  import gmw_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc_i,
  input  logic       clr_i,
  output logic [7:0] cnt_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = inc_i ? 8'd1 : 8'd0;
    end else if (inc_i) begin
      cnt_d = sat_inc8(cnt_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/group_mem_writer.sv
// Fills the ping-pong group memory half that the frame generator is not reading.
// Optional macro GMW_STATS_EN adds saturating overflow/underrun counters and iStatClr.
module group_mem_writer
  import gmw_pkg::*;
#(
  parameter int                 ADDR_W    = $clog2(BANK_DEPTH),
  parameter int                 DATA_W    = WORD_W,
  parameter logic [DATA_W-1:0]  FILL_WORD = FILL_WORD_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iSwitch,
  input  logic [DATA_W-1:0] iData,
  input  logic              iValid,
  output logic              oReady,
  input  logic              iFlush,
  output logic              oWrEn,
  output logic [ADDR_W:0]   oWrAddr,
  output logic [DATA_W-1:0] oWrData,
  output logic              oBankFull,
  output logic              oOverflow,
  output logic              oUnderrun,
`ifdef GMW_STATS_EN
  input  logic              iStatClr,
  output logic [7:0]        oOvfCnt,
  output logic [7:0]        oUndCnt,
`endif
  output gmw_state_e        oDbgState
);

  // Handshake: a word transfers on every rising clk edge where iValid && oReady;
  // oReady depends only on state, and iValid while !oReady drops the word.

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  gmw_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              bank_q, bank_d;
  logic              sw_prev_q;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              ovf_q, ovf_d;
  logic              und_q, und_d;
  logic              sw_edge;
  logic              accept;

  assign sw_edge = (iSwitch != sw_prev_q);
  assign oReady  = (state_q == FILL);
  assign accept  = iValid && oReady;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bank_d    = bank_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ovf_d     = iValid && !oReady && !sw_edge;
    und_d     = 1'b0;

    if (sw_edge) begin
      // The generator just moved to bank iSwitch; restart filling the other one.
      state_d = FILL;
      bank_d  = ~iSwitch;
      cnt_d   = '0;
      und_d   = (state_q != FULL);
      if (accept) begin
        wr_en_d   = 1'b1;
        wr_addr_d = {~iSwitch, {ADDR_W{1'b0}}};
        wr_data_d = iData;
        cnt_d     = ADDR_W'(1);
      end
    end else begin
      unique case (state_q)
        FILL: begin
          if (accept) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {bank_q, cnt_q};
            wr_data_d = iData;
            if (cnt_q == LAST_ADDR) begin
              state_d = FULL;
            end else begin
              cnt_d = cnt_q + ADDR_W'(1);
              if (iFlush && (cnt_q != '0)) state_d = PAD;
            end
          end else if (iFlush && (cnt_q != '0)) begin
            state_d = PAD;
          end
        end
        PAD: begin
          wr_en_d   = 1'b1;
          wr_addr_d = {bank_q, cnt_q};
          wr_data_d = FILL_WORD;
          if (cnt_q == LAST_ADDR) state_d = FULL;
          else                    cnt_d   = cnt_q + ADDR_W'(1);
        end
        FULL: begin
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      bank_q    <= 1'b1;
      sw_prev_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ovf_q     <= 1'b0;
      und_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bank_q    <= bank_d;
      sw_prev_q <= iSwitch;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ovf_q     <= ovf_d;
      und_q     <= und_d;
    end
  end

  assign oWrEn     = wr_en_q;
  assign oWrAddr   = wr_addr_q;
  assign oWrData   = wr_data_q;
  assign oBankFull = (state_q == FULL);
  assign oOverflow = ovf_q;
  assign oUnderrun = und_q;
  assign oDbgState = state_q;

`ifdef GMW_STATS_EN
  // Counters take the same-cycle event so they step together with the output pulses.
  gmw_sat_cnt u_ovf_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (ovf_d),
    .clr_i (iStatClr),
    .cnt_o (oOvfCnt)
  );

  gmw_sat_cnt u_und_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (und_d),
    .clr_i (iStatClr),
    .cnt_o (oUndCnt)
  );
`endif

endmodule

// File: tb/tb_group_mem_writer.sv
// Randomized bench for group_mem_writer with a bank-level reference model and write scoreboard.
// Build with GMW_STATS_EN defined to also exercise the statistics counters.
`timescale 1ns/1ps
module tb_group_mem_writer;
  import gmw_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 12;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam logic [DATA_W-1:0] FILLW = 12'h000;
  localparam int W = 32 + ADDR_W + 1 + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #40 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              sw = 1'b0, valid = 1'b0, flush = 1'b0, clr = 1'b0;
  logic [DATA_W-1:0] data = '0;
  logic              ready, wr_en, bank_full, ovf, und;
  logic [ADDR_W:0]   wr_addr;
  logic [DATA_W-1:0] wr_data;
  gmw_state_e        dbg_state;
`ifdef GMW_STATS_EN
  logic [7:0]        ovf_cnt, und_cnt;
`endif

  group_mem_writer dut (
    .clk       (clk),
    .reset     (reset),
    .iSwitch   (sw),
    .iData     (data),
    .iValid    (valid),
    .oReady    (ready),
    .iFlush    (flush),
    .oWrEn     (wr_en),
    .oWrAddr   (wr_addr),
    .oWrData   (wr_data),
    .oBankFull (bank_full),
    .oOverflow (ovf),
    .oUnderrun (und),
`ifdef GMW_STATS_EN
    .iStatClr  (clr),
    .oOvfCnt   (ovf_cnt),
    .oUndCnt   (und_cnt),
`endif
    .oDbgState (dbg_state)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // A bank is a count of words written so far; padding is a flag that
  // finishes the bank with fill words one per cycle.
  int m_level, ovf_m, und_m;
  bit m_pad, m_bank, m_swprev;
  bit exp_ready = 1'b1, exp_full = 1'b0;
  bit mon_en = 1'b0;

  logic [W-1:0] exp_q[$];
  int           ovf_q[$];
  int           und_q[$];

  function automatic int sat_add(input int v, input bit ev, input bit c);
    if (c) return ev ? 1 : 0;
    if (ev) return (v < 255) ? v + 1 : 255;
    return v;
  endfunction

  task automatic push_wr(input bit b, input int a, input logic [DATA_W-1:0] d);
    exp_q.push_back({32'(cyc + 1), b, ADDR_W'(a), d});
  endtask

  task automatic model_reset();
    m_level = 0; m_pad = 0; m_bank = 1; m_swprev = 0;
    ovf_m = 0; und_m = 0;
    exp_ready = 1; exp_full = 0;
    exp_q.delete(); ovf_q.delete(); und_q.delete();
  endtask

  task automatic model_step(input bit s, input bit v, input logic [DATA_W-1:0] d,
                            input bit f, input bit c);
    bit rdy, e, o, u;
    int pre;
    rdy = !m_pad && (m_level < DEPTH);
    e   = (s != m_swprev);
    exp_ready = rdy;
    exp_full  = (m_level == DEPTH);
    u = e && (m_level < DEPTH);
    o = v && !rdy && !e;
    if (e) begin
      m_bank = !s; m_level = 0; m_pad = 0;
      if (v && rdy) begin push_wr(m_bank, 0, d); m_level = 1; end
    end else if (m_pad) begin
      push_wr(m_bank, m_level, FILLW);
      m_level++;
      if (m_level == DEPTH) m_pad = 0;
    end else if (rdy) begin
      pre = m_level;
      if (v) begin push_wr(m_bank, m_level, d); m_level++; end
      if (f && pre != 0 && m_level < DEPTH) m_pad = 1;
    end
    if (o) ovf_q.push_back(cyc + 1);
    if (u) und_q.push_back(cyc + 1);
    ovf_m = sat_add(ovf_m, o, c);
    und_m = sat_add(und_m, u, c);
    m_swprev = s;
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input bit s, input bit v, input logic [DATA_W-1:0] d, input bit f);
    sw = s; valid = v; data = d; flush = f;
    model_step(s, v, d, f, clr);
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0; sw = 0; valid = 0; flush = 0; clr = 0; data = '0;
    model_reset();
    #5;
    chk("rst_ready", int'(ready), 1);
    chk("rst_wren", int'(wr_en), 0);
    chk("rst_addr", int'(wr_addr), 0);
    chk("rst_data", int'(wr_data), 0);
    chk("rst_full", int'(bank_full), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_und", int'(und), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [W-1:0] mon_e;
  always @(negedge clk) begin
    if (reset && mon_en) begin
      chk("ready", int'(ready), int'(exp_ready));
      chk("bank_full", int'(bank_full), int'(exp_full));
      while (exp_q.size() > 0 && int'(exp_q[0][W-1 -: 32]) < cyc) begin
        mon_e = exp_q.pop_front();
        chk("missed_write_addr", -1, int'(mon_e[ADDR_W+DATA_W:DATA_W]));
      end
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", int'(wr_addr), -1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("write_cycle", cyc, int'(mon_e[W-1 -: 32]));
          chk("write_addr", int'(wr_addr), int'(mon_e[ADDR_W+DATA_W:DATA_W]));
          chk("write_data", int'(wr_data), int'(mon_e[DATA_W-1:0]));
        end
      end
      while (ovf_q.size() > 0 && ovf_q[0] < cyc)
        chk("missed_overflow", -1, ovf_q.pop_front());
      if (ovf) begin
        if (ovf_q.size() == 0) chk("unexpected_overflow", cyc, -1);
        else                   chk("overflow_cycle", cyc, ovf_q.pop_front());
      end
      while (und_q.size() > 0 && und_q[0] < cyc)
        chk("missed_underrun", -1, und_q.pop_front());
      if (und) begin
        if (und_q.size() == 0) chk("unexpected_underrun", cyc, -1);
        else                   chk("underrun_cycle", cyc, und_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  bit sw_cur;
  initial begin
    @(posedge clk); #1;
    do_reset();
    mon_en = 1'b1;
    sw_cur = 0;

    // Fill bank 1 with an address ramp, then hold valid against a full bank.
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, DATA_W'(i), 0);
    cycle(0, 0, '0, 0);
    chk("full_after_ramp", int'(bank_full), 1);
    for (int i = 0; i < 3; i++) cycle(0, 1, DATA_W'($urandom), 0);
    sw_cur = 1;
    for (int i = 0; i < 8; i++) cycle(sw_cur, 1, DATA_W'($urandom), 0);

    // Random traffic with occasional flushes and bank switches.
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 699) == 0) sw_cur = !sw_cur;
      cycle(sw_cur, $urandom_range(0, 3) != 0, DATA_W'($urandom),
            $urandom_range(0, 249) == 0);
    end

    // 100 words then flush: padding runs to the end of the bank.
    sw_cur = !sw_cur;
    cycle(sw_cur, 0, '0, 0);
    for (int i = 0; i < 100; i++) cycle(sw_cur, 1, DATA_W'($urandom), 0);
    cycle(sw_cur, 0, '0, 1);
    for (int i = 0; i < 930; i++) cycle(sw_cur, $urandom_range(0, 1) == 1, DATA_W'($urandom), 0);
    chk("full_after_pad", int'(bank_full), 1);
    sw_cur = !sw_cur;
    cycle(sw_cur, 0, '0, 0);

    // 500 words then a switch with a word in the edge cycle.
    for (int i = 0; i < 499; i++) cycle(sw_cur, 1, DATA_W'($urandom), 0);
    sw_cur = !sw_cur;
    cycle(sw_cur, 1, DATA_W'($urandom), 0);
    cycle(sw_cur, 1, DATA_W'($urandom), 0);
    for (int i = 0; i < 20; i++) cycle(sw_cur, $urandom_range(0, 1) == 1, DATA_W'($urandom), 0);

    // Reset while padding around address 600.
    sw_cur = !sw_cur;
    cycle(sw_cur, 0, '0, 0);
    for (int i = 0; i < 300; i++) cycle(sw_cur, 1, DATA_W'($urandom), 0);
    cycle(sw_cur, 0, '0, 1);
    for (int i = 0; i < 300; i++) cycle(sw_cur, 0, '0, 0);
    do_reset();
    sw_cur = 0;
    cycle(0, 1, 12'hABC, 0);
    chk("post_reset_addr", int'(wr_addr), 'h400);
    for (int i = 0; i < 10; i++) cycle(0, 1, DATA_W'($urandom), 0);

`ifdef GMW_STATS_EN
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, DATA_W'($urandom), 0);
    for (int i = 0; i < 300; i++) cycle(0, 1, DATA_W'($urandom), 0);
    chk("ovf_cnt_model", int'(ovf_cnt), ovf_m);
    chk("ovf_cnt_sat", int'(ovf_cnt), 255);
    clr = 1'b1;
    cycle(0, 1, '0, 0);
    chk("ovf_cnt_clr_event", int'(ovf_cnt), 1);
    cycle(1, 0, '0, 0);
    cycle(0, 0, '0, 0);
    chk("und_cnt_model", int'(und_cnt), und_m);
    clr = 1'b1;
    cycle(0, 0, '0, 0);
    chk("und_cnt_clr", int'(und_cnt), 0);
`endif

    for (int i = 0; i < 3; i++) cycle(sw_cur, 0, '0, 0);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("ovf_q_drained", ovf_q.size(), 0);
    chk("und_q_drained", und_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
